collatz_engine: RTL

COLLATZ_ENGINE -- requirements
Module: collatz_engine

---
 rtl/collatz_pkg.sv | 17 +
 rtl/collatz_step.sv | 32 +++
 rtl/collatz_engine.sv | 121 ++++++++++++
 3 files changed

// File: rtl/collatz_pkg.sv
// Shared definitions for the Collatz orbit engine: FSM state encoding and status codes.
package collatz_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_RUN  = 2'b01,
    S_DONE = 2'b10
  } state_e;

  typedef logic [1:0] status_t;

  localparam status_t ST_OK        = 2'b00;
  localparam status_t ST_OVERFLOW  = 2'b01;
  localparam status_t ST_TIMEOUT   = 2'b10;
  localparam status_t ST_ZERO_SEED = 2'b11;

endpackage

// File: rtl/collatz_step.sv
// One combinational Collatz step: halve even iterates, 3n+1 (optionally fused with /2) for odd.
module collatz_step #(
  parameter int unsigned WIDTH = 144
) (
  input  logic [WIDTH-1:0] iter,
  input  logic             mode,
  output logic [WIDTH-1:0] next_iter,
  output logic [1:0]       step_inc,
  output logic             ovf
);

  localparam int unsigned XW = WIDTH + 2;

  logic [XW-1:0] tripled;
  logic [XW-1:0] odd_val;

  // Two guard bits hold 3n+1 for any WIDTH-bit n; overflow is judged after the optional halving.
  always_comb begin
    tripled = XW'(iter) + (XW'(iter) << 1) + XW'(1);
    odd_val = mode ? (tripled >> 1) : tripled;
    if (iter[0]) begin
      next_iter = odd_val[WIDTH-1:0];
      step_inc  = mode ? 2'd2 : 2'd1;
      ovf       = |odd_val[XW-1:WIDTH];
    end else begin
      next_iter = iter >> 1;
      step_inc  = 2'd1;
      ovf       = 1'b0;
    end
  end

endmodule

// File: rtl/collatz_engine.sv
// Iterates the Collatz map from a seed, reporting orbit length, peak iterate and termination status.
module collatz_engine
  import collatz_pkg::*;
#(
  parameter int unsigned WIDTH  = 144,
  parameter int unsigned OLEN_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start_valid,
  output logic              start_ready,
  input  logic [WIDTH-1:0]  seed,
  input  logic              shortcut,
  input  logic              abort,
  output logic              busy,
  output logic              done_valid,
  input  logic              done_ready,
  output logic [OLEN_W-1:0] orbit_len,
  output logic [WIDTH-1:0]  path_record,
  output logic [1:0]        status
);

  localparam int unsigned SUM_W = OLEN_W + 2;
  localparam logic [SUM_W-1:0] OLEN_MAX = {2'b00, {OLEN_W{1'b1}}};

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   iter_q, iter_d;
  logic [OLEN_W-1:0]  olen_q, olen_d;
  logic [WIDTH-1:0]   rec_q, rec_d;
  logic               mode_q, mode_d;
  status_t            status_q, status_d;

  logic [WIDTH-1:0]   step_next;
  logic [1:0]         step_inc;
  logic               step_ovf;
  logic [SUM_W-1:0]   olen_sum;

  collatz_step #(.WIDTH(WIDTH)) u_step (
    .iter      (iter_q),
    .mode      (mode_q),
    .next_iter (step_next),
    .step_inc  (step_inc),
    .ovf       (step_ovf)
  );

  // Next-state logic; a terminating cycle (overflow or timeout) leaves iter and record untouched.
  always_comb begin
    state_d  = state_q;
    iter_d   = iter_q;
    olen_d   = olen_q;
    rec_d    = rec_q;
    mode_d   = mode_q;
    status_d = status_q;
    olen_sum = SUM_W'(olen_q) + SUM_W'(step_inc);
    case (state_q)
      S_IDLE: begin
        if (start_valid) begin
          iter_d   = seed;
          olen_d   = '0;
          rec_d    = seed;
          mode_d   = shortcut;
          status_d = ST_OK;
          if (seed == '0) begin
            state_d  = S_DONE;
            status_d = ST_ZERO_SEED;
          end else begin
            state_d = S_RUN;
          end
        end
      end
      S_RUN: begin
        if (abort) begin
          state_d = S_IDLE;
        end else if (iter_q == WIDTH'(1)) begin
          state_d = S_DONE;
        end else if (step_ovf) begin
          state_d  = S_DONE;
          status_d = ST_OVERFLOW;
        end else if (olen_sum > OLEN_MAX) begin
          olen_d   = '1;
          state_d  = S_DONE;
          status_d = ST_TIMEOUT;
        end else begin
          iter_d = step_next;
          olen_d = OLEN_W'(olen_sum);
          if (step_next > rec_q) rec_d = step_next;
        end
      end
      S_DONE: begin
        if (done_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      iter_q   <= '0;
      olen_q   <= '0;
      rec_q    <= '0;
      mode_q   <= 1'b0;
      status_q <= ST_OK;
    end else begin
      state_q  <= state_d;
      iter_q   <= iter_d;
      olen_q   <= olen_d;
      rec_q    <= rec_d;
      mode_q   <= mode_d;
      status_q <= status_d;
    end
  end

  assign start_ready = (state_q == S_IDLE);
  assign busy        = (state_q == S_RUN);
  assign done_valid  = (state_q == S_DONE);
  assign orbit_len   = olen_q;
  assign path_record = rec_q;
  assign status      = status_q;

endmodule
